uart_byte_rx: RTL

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled UART byte receiver with a single-entry
// holding register, framing-error and overrun pulses.
module uart_byte_rx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    // Rounded oversample divider, never below one clock per tick.
    localparam int DIV_CALC = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
    localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] MID_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rxd_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [SW-1:0] smp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          done;

    assign rxd_s   = sync[1];
    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign rx_busy = (state != IDLE);
    // A good stop bit on its last oversample tick completes the byte.
    assign done    = (state == STOP) && tick && (smp_cnt == BIT_LAST) && rxd_s;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], UART_RXD};
    end

    // Oversample tick divider; held at zero in IDLE so every frame
    // starts its tick phase fresh from the start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                div_cnt <= '0;
        else if (state == IDLE)    div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                       div_cnt <= div_cnt + 1'b1;
    end

    // Frame FSM: start-bit qualification, LSB-first data shift, stop check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        smp_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_cnt == MID_LAST) begin
                            smp_cnt <= '0;
                            bit_idx <= '0;
                            // Still low at mid-bit: a real start bit, else a glitch.
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (smp_cnt == BIT_LAST) begin
                            smp_cnt <= '0;
                            shreg   <= {rxd_s, shreg[7:1]};
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (smp_cnt == BIT_LAST) begin
                            smp_cnt <= '0;
                            if (rxd_s) begin
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Wait out a held-low line; only a return to high re-arms.
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: load on completion if empty or being drained the
    // same cycle, otherwise drop the new byte and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
